moore_seq_generator: RTL and testbench
======================================

// Module: moore_seq_generator
// PURPOSE
//   Serial pattern transmitter: the sending end of the bit-serial sequence-detector link.
//   On a start request it emits a fixed PATTERN (default 011011), MSB first, one bit per clk.
//   The pattern is repeated 'reps' times, with an optional idle gap between repetitions.
//   Drives the 'in' input of the sequence detector, in benches and in on-chip self-test.
// PARAMETERS
//   LEN      6          pattern length in bits (2..16)
//   PATTERN  6'b011011  bits sent MSB (bit LEN-1) first
//   GAP      0          idle cycles (out=0, out_valid=0) between repetitions (0..15)
// PORTS
//   clk        in   1  rising-edge clock
//   reset      in   1  asynchronous, active-low reset
//   start      in   1  request; sampled in IDLE only
//   reps       in   4  repetition count, latched on accepted start; 0 = start ignored
//   abort      in   1  synchronous cancel of a transfer in progress
//   out        out  1  serial data bit
//   out_valid  out  1  high while 'out' carries a pattern bit
//   busy       out  1  high from the cycle after an accepted start until DONE
//   done       out  1  one-cycle pulse after the final bit of the final repetition
// BEHAVIOUR
// - Reset (reset=0, any time, asynchronous):
//   - state=IDLE; out=0, out_valid=0, busy=0, done=0.
//   - Bit index, gap counter and rep counter cleared.
// - Moore FSM. All outputs are registered and decoded from state only.
//   - IDLE: outputs 0. start=1 & reps!=0 at edge t0 -> latch reps, bit_idx=LEN-1, go to SEND.
//   - SEND: out=PATTERN[bit_idx], out_valid=1, busy=1; bit_idx decrements each cycle.
//     - bit_idx==0 & rep_cnt>1 -> rep_cnt--, bit_idx=LEN-1; go to GAP if GAP>0, else stay in SEND.
//     - bit_idx==0 & rep_cnt==1 -> DONE.
//   - GAP: out=0, out_valid=0, busy=1. Exactly GAP cycles, then SEND with bit_idx=LEN-1.
//   - DONE: done=1, busy=0, out=0, out_valid=0. Exactly one cycle, then IDLE.
// - Latency and length:
//   - First bit is visible in the cycle after edge t0.
//   - Transfer length: reps*LEN + (reps-1)*GAP cycles, followed by one DONE cycle.
//   - Back-to-back repetitions with GAP=0 form a continuous stream with no bubble.
// - start while not in IDLE (SEND, GAP or DONE) is ignored. Requests are not queued.
//   - start held high through DONE is accepted in the IDLE cycle that follows.
// - reps changes after acceptance have no effect on the transfer in progress.
// - abort:
//   - abort=1 in SEND/GAP -> IDLE at the next edge. done stays 0; outputs go 0 in that cycle.
//   - abort in IDLE or DONE has no effect.
//   - abort and start asserted together in IDLE -> abort wins; start is ignored.
// - Reset deasserted mid-transfer: the block restarts from IDLE. No residual done pulse.
// - Counters are sized to LEN and GAP. bit_idx never wraps past 0 into an out-of-range value.
// TESTING
// 1. Reset=0 for 2 cycles, then release -> out=0, out_valid=0, busy=0, done=0; idle with start=0.
// 2. start pulse, reps=1, GAP=0 -> out = 0,1,1,0,1,1 on 6 consecutive valid cycles.
//    - done=1 on cycle 7, then IDLE.
//    - Loopback into the detector: y asserts once, right after the 6th bit.
// 3. reps=5, GAP=0 -> 30 contiguous valid bits, 011011 x5; busy high for 30 cycles; done on cycle 31.
// 4. reps=2, GAP=2 -> 6 valid bits, 2 cycles with out_valid=0, 6 valid bits, then done.
//    - 14 cycles total before DONE.
// 5. reps=3, abort on the 4th bit of repetition 2 -> IDLE next edge, done never pulses.
//    - A start in the following cycle is accepted.
// 6. Corner cases:
//    - reps=0 with start -> no activity.
//    - start pulsed during SEND -> ignored; transfer length unchanged.
//    - reset=0 mid-SEND -> outputs 0 immediately (asynchronously).

Source files
------------

// File: rtl/moore_seq_generator.sv
// Serial pattern transmitter: sends PATTERN MSB-first 'reps' times, with an optional
// idle gap between repetitions. All outputs are registered from the next state.
module moore_seq_generator #(
  parameter int unsigned    LEN     = 6,
  parameter logic [LEN-1:0] PATTERN = LEN'(6'b011011),
  parameter int unsigned    GAP     = 0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [3:0] reps_i,
  input  logic       abort_i,
  output logic       out_o,
  output logic       out_valid_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int unsigned    IW       = $clog2(LEN);
  localparam logic [IW-1:0]  LAST_IDX = IW'(LEN - 1);
  localparam logic [3:0]     GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] bit_q, bit_d;
  logic [3:0]    gap_q, gap_d;
  logic [3:0]    rep_q, rep_d;
  logic          out_q, out_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      bit_q   <= '0;
      gap_q   <= '0;
      rep_q   <= '0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      rep_q   <= rep_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Output registers are loaded from the next state so they line up with state_q.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    rep_d   = rep_q;

    unique case (state_q)
      S_IDLE: begin
        if (!abort_i && start_i && (reps_i != 4'd0)) begin
          state_d = S_SEND;
          bit_d   = LAST_IDX;
          rep_d   = reps_i;
        end
      end
      S_SEND: begin
        if (abort_i) begin
          state_d = S_IDLE;
          bit_d   = '0;
          gap_d   = '0;
          rep_d   = '0;
        end else if (bit_q != '0) begin
          bit_d = bit_q - 1'b1;
        end else if (rep_q > 4'd1) begin
          rep_d = rep_q - 1'b1;
          bit_d = LAST_IDX;
          if (GAP > 0) begin
            state_d = S_GAP;
            gap_d   = GAP_LOAD;
          end
        end else begin
          state_d = S_DONE;
          rep_d   = '0;
        end
      end
      S_GAP: begin
        if (abort_i) begin
          state_d = S_IDLE;
          bit_d   = '0;
          gap_d   = '0;
          rep_d   = '0;
        end else if (gap_q == 4'd0) begin
          state_d = S_SEND;
          bit_d   = LAST_IDX;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    out_d   = (state_d == S_SEND) ? PATTERN[bit_d] : 1'b0;
    valid_d = (state_d == S_SEND);
    busy_d  = (state_d == S_SEND) || (state_d == S_GAP);
    done_d  = (state_d == S_DONE);
  end

  assign out_o       = out_q;
  assign out_valid_o = valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_moore_seq_generator.sv
// Directed bench for moore_seq_generator: one instance with GAP=0, one with GAP=2.
// Outputs are sampled on the falling edge as {out, out_valid, busy, done}.
module tb_moore_seq_generator;

  logic       clk;
  logic       rstN;
  logic       start, start2;
  logic [3:0] reps;
  logic       abort;
  logic       out1, valid1, busy1, done1;
  logic       out2, valid2, busy2, done2;

  int vecCount  = 0;
  int missCount = 0;

  localparam logic [5:0] PAT    = 6'b011011;
  localparam logic [3:0] V_IDLE = 4'b0000;
  localparam logic [3:0] V_GAP  = 4'b0010;
  localparam logic [3:0] V_DONE = 4'b0001;

  moore_seq_generator #(.LEN(6), .PATTERN(6'b011011), .GAP(0)) dut (
    .clk_i(clk), .rst_ni(rstN), .start_i(start), .reps_i(reps), .abort_i(abort),
    .out_o(out1), .out_valid_o(valid1), .busy_o(busy1), .done_o(done1)
  );

  moore_seq_generator #(.LEN(6), .PATTERN(6'b011011), .GAP(2)) dutGap (
    .clk_i(clk), .rst_ni(rstN), .start_i(start2), .reps_i(reps), .abort_i(1'b0),
    .out_o(out2), .out_valid_o(valid2), .busy_o(busy2), .done_o(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] sendVec(input int pos);
    logic [5:0] p;
    p = PAT;
    return {p[5 - (pos % 6)], 3'b110};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vecCount++;
    assert (obs === exp)
    else begin
      missCount++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    rstN = 1'b0; start = 1'b0; start2 = 1'b0; reps = 4'd0; abort = 1'b0;
    tick(); tick();
    checkOutput("reset_dut", {out1, valid1, busy1, done1}, V_IDLE);
    checkOutput("reset_gap", {out2, valid2, busy2, done2}, V_IDLE);
    rstN = 1'b1;
    tick();
    checkOutput("idle_after_reset", {out1, valid1, busy1, done1}, V_IDLE);

    // Single repetition: 011011 then a one-cycle done.
    start = 1'b1; reps = 4'd1;
    tick();
    start = 1'b0; reps = 4'd0;
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("rep1_bit%0d", i), {out1, valid1, busy1, done1}, sendVec(i));
      tick();
    end
    checkOutput("rep1_done", {out1, valid1, busy1, done1}, V_DONE);
    tick();
    checkOutput("rep1_idle", {out1, valid1, busy1, done1}, V_IDLE);

    // Five repetitions with no gap: 30 contiguous bits.
    start = 1'b1; reps = 4'd5;
    tick();
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      checkOutput($sformatf("rep5_bit%0d", i), {out1, valid1, busy1, done1}, sendVec(i));
      tick();
    end
    checkOutput("rep5_done", {out1, valid1, busy1, done1}, V_DONE);
    tick();
    checkOutput("rep5_idle", {out1, valid1, busy1, done1}, V_IDLE);

    // Two repetitions with a two-cycle gap on the GAP=2 instance.
    start2 = 1'b1; reps = 4'd2;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (i < 6)
        checkOutput($sformatf("gap_c%0d", i), {out2, valid2, busy2, done2}, sendVec(i));
      else if (i < 8)
        checkOutput($sformatf("gap_c%0d", i), {out2, valid2, busy2, done2}, V_GAP);
      else
        checkOutput($sformatf("gap_c%0d", i), {out2, valid2, busy2, done2}, sendVec(i - 8));
      tick();
    end
    checkOutput("gap_done", {out2, valid2, busy2, done2}, V_DONE);
    tick();
    checkOutput("gap_idle", {out2, valid2, busy2, done2}, V_IDLE);

    // Three repetitions aborted on the 4th bit of repetition 2, then restart.
    start = 1'b1; reps = 4'd3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("abort_bit%0d", i), {out1, valid1, busy1, done1}, sendVec(i));
      if (i == 9) abort = 1'b1;
      tick();
    end
    abort = 1'b0;
    checkOutput("abort_idle", {out1, valid1, busy1, done1}, V_IDLE);
    start = 1'b1; reps = 4'd1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("restart_bit%0d", i), {out1, valid1, busy1, done1}, sendVec(i));
      tick();
    end
    checkOutput("restart_done", {out1, valid1, busy1, done1}, V_DONE);
    tick();

    // abort together with start in IDLE: abort wins.
    start = 1'b1; abort = 1'b1; reps = 4'd3;
    tick();
    start = 1'b0; abort = 1'b0;
    checkOutput("abort_start_idle", {out1, valid1, busy1, done1}, V_IDLE);

    // reps=0 with start is ignored.
    start = 1'b1; reps = 4'd0;
    tick();
    start = 1'b0;
    checkOutput("reps0_c0", {out1, valid1, busy1, done1}, V_IDLE);
    tick();
    checkOutput("reps0_c1", {out1, valid1, busy1, done1}, V_IDLE);

    // start and reps changes during SEND do not alter the transfer.
    start = 1'b1; reps = 4'd1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("ign_bit%0d", i), {out1, valid1, busy1, done1}, sendVec(i));
      start = (i == 2);
      reps = (i == 2) ? 4'd5 : 4'd1;
      tick();
    end
    start = 1'b0;
    checkOutput("ign_done", {out1, valid1, busy1, done1}, V_DONE);
    tick();
    checkOutput("ign_idle", {out1, valid1, busy1, done1}, V_IDLE);

    // start held through DONE is taken in the following IDLE cycle.
    start = 1'b1; reps = 4'd1;
    tick();
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("held_bit%0d", i), {out1, valid1, busy1, done1}, sendVec(i));
      tick();
    end
    checkOutput("held_done", {out1, valid1, busy1, done1}, V_DONE);
    tick();
    checkOutput("held_idle", {out1, valid1, busy1, done1}, V_IDLE);
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("held2_bit%0d", i), {out1, valid1, busy1, done1}, sendVec(i));
      tick();
    end
    checkOutput("held2_done", {out1, valid1, busy1, done1}, V_DONE);
    tick();

    // Asynchronous reset mid-SEND clears outputs at once, no done afterwards.
    start = 1'b1; reps = 4'd5;
    tick();
    start = 1'b0;
    tick(); tick();
    checkOutput("pre_reset_bit2", {out1, valid1, busy1, done1}, sendVec(2));
    #2 rstN = 1'b0;
    #1 checkOutput("async_reset", {out1, valid1, busy1, done1}, V_IDLE);
    tick();
    rstN = 1'b1;
    tick();
    checkOutput("post_reset_c0", {out1, valid1, busy1, done1}, V_IDLE);
    tick();
    checkOutput("post_reset_c1", {out1, valid1, busy1, done1}, V_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
